// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter.
// Contents: FSM state enum, port-select enum, default address/data widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: data port, fetch port and shared memory port bundle.
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_stall,
        input  i_read, i_addr,
        output i_rdata, i_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_stall,
        output i_read, i_addr,
        input  i_rdata, i_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/arb_grant.sv
// arb_grant: combinational grant select between data and fetch requests.
// Ports: d_req, i_req, last_gnt (round-robin build only) -> gnt_valid, gnt_port.
// MEM_ARBITER_ROUND_ROBIN_EN: alternate on contention, else data wins.
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic  d_req,
    input  logic  i_req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  port_e last_gnt,
`endif
    output logic  gnt_valid,
    output port_e gnt_port
);

    always_comb begin
        gnt_valid = d_req | i_req;
        gnt_port  = PORT_D;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (d_req && i_req) begin
            gnt_port = (last_gnt == PORT_D) ? PORT_I : PORT_D;
        end else if (i_req) begin
            gnt_port = PORT_I;
        end
`else
        if (!d_req && i_req) begin
            gnt_port = PORT_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises MEM-stage data and IF-stage fetch accesses onto
// one shared memory port. Ports: clk, rst_n (async, active-low), bus
// (mem_arbiter_if.slave). Optional MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_done_q, d_done_d;
    logic              i_done_q, i_done_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    port_e             last_q, last_d;
`endif

    logic  d_req;
    logic  i_req;
    logic  gnt_valid;
    port_e gnt_port;

    assign d_req = bus.d_read | bus.d_write;
    assign i_req = bus.i_read;

    arb_grant u_grant (
        .d_req     (d_req),
        .i_req     (i_req),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        .last_gnt  (last_q),
`endif
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;
        i_rdata_d   = i_rdata_q;
        d_done_d    = 1'b0;
        i_done_d    = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    mem_req_d = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_d    = gnt_port;
`endif
                    if (gnt_port == PORT_D) begin
                        state_d     = SERVE_D;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        // read+write together is a write
                        mem_we_d    = bus.d_write;
                    end else begin
                        state_d     = SERVE_I;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = '0;
                        mem_we_d    = 1'b0;
                    end
                end
            end
            SERVE_D: begin
                if (bus.mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            SERVE_I: begin
                if (bus.mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = bus.mem_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_rdata_q   <= '0;
            i_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q      <= PORT_I;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
            i_rdata_q   <= i_rdata_d;
            d_done_q    <= d_done_d;
            i_done_q    <= i_done_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_rdata   = i_rdata_q;
    // release only in the DONE cycle of the port's own access
    assign bus.d_stall   = d_req & ~d_done_q;
    assign bus.i_stall   = i_req & ~i_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters checked
// against a transaction-level model of arbitration and memory contents.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural memory
    logic [31:0] mem   [256];
    logic [31:0] model [256];
    int lat_sel   = 0;
    bit rand_spur = 1'b0;
    bit spur_req  = 1'b0;

    initial begin : memory
        bit serving;
        int cnt;
        serving = 1'b0;
        cnt = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'hA500_0000 | k;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            tick();
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (spur_req) begin
                spur_req = 1'b0;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end else if (!bus.mem_req) begin
                serving = 1'b0;
                if (rand_spur && $urandom_range(0, 5) == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                if (!serving) begin
                    serving = 1'b1;
                    cnt = (lat_sel >= 0) ? lat_sel : $urandom_range(0, 4);
                end
                if (cnt == 0) begin
                    serving = 1'b0;
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr[9:2]];
                    if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // transaction-level monitor for the random phase
    bit mon_en    = 1'b0;
    bit mon_first = 1'b0;
    bit p_d, p_i, p_dw, p_mreq;
    logic [31:0] p_da, p_dd, p_ia;
    bit pulse_d, pulse_i;
    port_e m_last, cur_port;
    logic [31:0] cur_a, cur_wd;
    bit cur_we;
    logic [31:0] d_last, i_last;

    always @(negedge clk) begin
        if (mon_en) begin : mon
            bit dp, ip, dc, ic;
            port_e e;
            dp = bus.d_read | bus.d_write;
            ip = bus.i_read;
            if (mon_first) begin
                mon_first = 1'b0;
                for (int k = 0; k < 256; k++) model[k] = mem[k];
                d_last = '0;
                i_last = '0;
                m_last = PORT_I;
                cur_port = PORT_D;
            end else begin
                if (bus.mem_req && !p_mreq) begin
                    if (p_d && p_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        e = (m_last == PORT_D) ? PORT_I : PORT_D;
`else
                        e = PORT_D;
`endif
                    end else begin
                        e = p_d ? PORT_D : PORT_I;
                    end
                    chk("grant_had_req", p_d | p_i, 1);
                    cur_port = e;
                    cur_we = (e == PORT_D) && p_dw;
                    cur_a  = (e == PORT_D) ? p_da : p_ia;
                    cur_wd = p_dd;
                    m_last = e;
                end
                if (bus.mem_req) begin
                    chk("mem_addr", bus.mem_addr, cur_a);
                    chk("mem_we", bus.mem_we, cur_we);
                    if (cur_we) chk("mem_wdata", bus.mem_wdata, cur_wd);
                end
                dc = dp && !bus.d_stall;
                ic = ip && !bus.i_stall;
                chk("d_release", dc, pulse_d);
                chk("i_release", ic, pulse_i);
                if (dc) begin
                    if (bus.d_write) model[bus.d_addr[9:2]] = bus.d_wdata;
                    else d_last = model[bus.d_addr[9:2]];
                end
                if (ic) i_last = model[bus.i_addr[9:2]];
                chk("d_rdata", bus.d_rdata, d_last);
                chk("i_rdata", bus.i_rdata, i_last);
            end
            pulse_d = bus.mem_req && bus.mem_ready && cur_port == PORT_D;
            pulse_i = bus.mem_req && bus.mem_ready && cur_port == PORT_I;
            p_d = dp;
            p_i = ip;
            p_dw = bus.d_write;
            p_da = bus.d_addr;
            p_dd = bus.d_wdata;
            p_ia = bus.i_addr;
            p_mreq = bus.mem_req;
        end
    end

    task automatic d_xfer(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat,
                          output int cyc, output logic [31:0] rv);
        lat_sel = lat;
        bus.d_read = rd;
        bus.d_write = wr;
        bus.d_addr = a;
        bus.d_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.d_stall && cyc < 200);
        rv = bus.d_rdata;
        tick();
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic i_xfer(input logic [31:0] a, input int lat,
                          output int cyc, output logic [31:0] rv);
        lat_sel = lat;
        bus.i_read = 1'b1;
        bus.i_addr = a;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.i_stall && cyc < 200);
        rv = bus.i_rdata;
        tick();
        bus.i_read = 1'b0;
    endtask

    task automatic run_d(input int n);
        for (int k = 0; k < n; k++) begin
            int op, w;
            repeat ($urandom_range(0, 3)) tick();
            op = $urandom_range(0, 9);
            bus.d_addr = $urandom_range(0, 7) * 4;
            bus.d_wdata = $urandom;
            bus.d_read = (op < 5) || (op == 9);
            bus.d_write = (op >= 5);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (bus.d_stall && w < 500);
            chk("d_wait", bus.d_stall, 0);
            tick();
            bus.d_read = 1'b0;
            bus.d_write = 1'b0;
        end
    endtask

    task automatic run_i(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            repeat ($urandom_range(0, 3)) tick();
            bus.i_addr = $urandom_range(0, 7) * 4;
            bus.i_read = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (bus.i_stall && w < 500);
            chk("i_wait", bus.i_stall, 0);
            tick();
            bus.i_read = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, n;
        logic [31:0] rv, first_a, d_val, i_val;
        bit ok, stable, dd, id, dc, ic;
        port_e first_done, exp_first;

        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.i_read = 1'b0;
        bus.i_addr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        bus.d_read = 1'b1;
        bus.i_read = 1'b1;
        #1;
        chk("rst_d_stall", bus.d_stall, 1);
        chk("rst_i_stall", bus.i_stall, 1);
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // long write, requester inputs disturbed mid-access
        lat_sel = 20;
        bus.d_write = 1'b1;
        bus.d_addr = 32'h0;
        bus.d_wdata = 32'h4;
        n = 0;
        cyc = 0;
        stable = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req) begin
                n++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0 ||
                    bus.mem_wdata !== 32'h4) stable = 1'b0;
            end
            if (n == 5) begin
                bus.d_addr = 32'h3C;
                bus.d_wdata = 32'h77;
            end
        end while (bus.d_stall && cyc < 100);
        chk("w20_stable", stable, 1);
        chk("w20_req_cycles", n, 21);
        chk("w20_release_cycle", cyc, 23);
        chk("w20_req_dropped", bus.mem_req, 0);
        tick();
        chk("w20_stall_1cyc", bus.d_stall, 1);
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;

        // write then read back, fetch data untouched
        d_xfer(1'b0, 1'b1, 32'h4, 32'h8, 0, cyc, rv);
        chk("wr_min_latency", cyc, 3);
        d_xfer(1'b1, 1'b0, 32'h4, 32'h0, 2, cyc, rv);
        chk("rd_latency", cyc, 5);
        chk("rd_data", rv, 32'h8);
        chk("rd_i_untouched", bus.i_rdata, 0);
        d_xfer(1'b1, 1'b1, 32'h10, 32'h55, 0, cyc, rv);
        chk("rw_is_write_hold", bus.d_rdata, 32'h8);

        // simultaneous data read and fetch
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_first = PORT_I;
`else
        exp_first = PORT_D;
`endif
        lat_sel = 1;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h4;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        first_a = '0;
        first_done = PORT_D;
        d_val = '0;
        i_val = '0;
        ok = 1'b1;
        dd = 1'b0;
        id = 1'b0;
        stable = 1'b0;
        for (int c = 0; c < 60 && !(dd && id); c++) begin
            @(negedge clk);
            if (bus.mem_req && !stable) begin
                stable = 1'b1;
                first_a = bus.mem_addr;
            end
            dc = bus.d_read && !bus.d_stall;
            ic = bus.i_read && !bus.i_stall;
            if (!dd && !id) begin
                if (exp_first == PORT_D) ok &= bus.i_stall;
                else ok &= bus.d_stall;
            end
            if (dc) begin
                if (!id) first_done = PORT_D;
                dd = 1'b1;
                d_val = bus.d_rdata;
            end
            if (ic) begin
                if (!dd) first_done = PORT_I;
                id = 1'b1;
                i_val = bus.i_rdata;
            end
            tick();
            if (dc) bus.d_read = 1'b0;
            if (ic) bus.i_read = 1'b0;
        end
        chk("both_completed", dd && id, 1);
        chk("first_addr", first_a, (exp_first == PORT_D) ? 32'h4 : 32'h100);
        chk("first_port", first_done, exp_first);
        chk("loser_stalled", ok, 1);
        chk("both_d_data", d_val, 32'h8);
        chk("both_i_data", i_val, 32'hA500_0040);

        // fetch dropped mid-access still completes
        lat_sel = 3;
        bus.i_addr = 32'hC;
        bus.i_read = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.mem_req && cyc < 20);
        tick();
        bus.i_read = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop_i_rdata", bus.i_rdata, 32'hA500_0003);
        chk("drop_mem_req", bus.mem_req, 0);
        tick();
        i_xfer(32'h8, 0, cyc, rv);
        chk("i_min_latency", cyc, 3);
        chk("i_data", rv, 32'hA500_0002);

        // reset in the middle of a fetch
        lat_sel = 10;
        bus.i_addr = 32'h14;
        bus.i_read = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.mem_req && cyc < 20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_i_rdata", bus.i_rdata, 0);
        chk("midrst_i_stall", bus.i_stall, 1);
        bus.i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        spur_req = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            ok &= (bus.mem_req == 1'b0) && (bus.i_rdata == 32'h0) &&
                  (bus.d_rdata == 32'h0);
        end
        chk("rst_abandon", ok, 1);
        tick();
        i_xfer(32'h14, 0, cyc, rv);
        chk("post_rst_latency", cyc, 3);
        chk("post_rst_data", rv, 32'hA500_0005);

        // stray mem_ready while idle
        spur_req = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ok &= (bus.mem_req == 1'b0) && (bus.mem_addr == 32'h14) &&
                  (bus.mem_we == 1'b0) && (bus.i_rdata == 32'hA500_0005) &&
                  (bus.d_rdata == 32'h0);
        end
        chk("idle_ready_ignored", ok, 1);
        tick();
        d_xfer(1'b1, 1'b0, 32'h4, 32'h0, 0, cyc, rv);
        chk("idle_ready_latency", cyc, 3);
        chk("idle_ready_data", rv, 32'h8);

        // randomized traffic against the model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        lat_sel = -1;
        rand_spur = 1'b1;
        mon_first = 1'b1;
        mon_en = 1'b1;
        fork
            run_d(80);
            run_i(80);
        join
        repeat (5) tick();
        mon_en = 1'b0;
        rand_spur = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
